// File: rtl/multdiv_sequencer_if.sv
// Execute-stage <-> multdiv sequencer bundle: issue side, unit handshake and writeback.
// master = pipeline/unit side, slave = sequencer.
interface multdiv_sequencer_if;
    logic        issue_valid;
    logic        issue_op;
    logic [4:0]  issue_rd;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        md_mult;
    logic        md_div;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;
    logic        stall;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport master (
        output issue_valid, issue_op, issue_rd, operand_a, operand_b, flush,
               md_result, md_exception, md_ready,
        input  md_mult, md_div, md_a, md_b, stall, busy, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  issue_valid, issue_op, issue_rd, operand_a, operand_b, flush,
               md_result, md_exception, md_ready,
        output md_mult, md_div, md_a, md_b, stall, busy, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Sequences the iterative mult/div unit: one start pulse, stall while running, timeout, one writeback.
// Optional zero-operand shortcut enabled by defining MDSEQ_FASTPATH_EN.
//
// state | meaning
// IDLE  | waiting for an issue from DX
// START | operands latched, start pulse to the unit
// WAIT  | unit running, cycle counter active
// DONE  | single writeback beat
module multdiv_sequencer #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 8
) (
    input logic              clock,
    input logic              reset,
    multdiv_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MAX_CYCLES - 1);
    localparam logic [4:0]       EXC_RD      = 5'd30;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op;
    logic [4:0]       rd;
    logic [31:0]      a_q, b_q;
    logic             pulse_mult, pulse_div;
    logic             wb_valid_q;
    logic [4:0]       wb_rd_q;
    logic [31:0]      wb_data_q;
    logic             fast_hit, fast_exc;

    function automatic logic [31:0] exc_code(input logic is_div);
        return is_div ? 32'd5 : 32'd4;
    endfunction

    always_comb begin
        fast_hit = 1'b0;
        fast_exc = 1'b0;
`ifdef MDSEQ_FASTPATH_EN
        if (bus.issue_op) begin
            fast_hit = (bus.operand_b == 32'd0);
            fast_exc = 1'b1;
        end else begin
            fast_hit = (bus.operand_a == 32'd0) || (bus.operand_b == 32'd0);
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op         <= 1'b0;
            rd         <= '0;
            a_q        <= '0;
            b_q        <= '0;
            pulse_mult <= 1'b0;
            pulse_div  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            pulse_mult <= 1'b0;
            pulse_div  <= 1'b0;
            wb_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.issue_valid && !bus.flush) begin
                        op  <= bus.issue_op;
                        rd  <= bus.issue_rd;
                        a_q <= bus.operand_a;
                        b_q <= bus.operand_b;
                        if (fast_hit) begin
                            state      <= DONE;
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= fast_exc ? EXC_RD : bus.issue_rd;
                            wb_data_q  <= fast_exc ? exc_code(bus.issue_op) : 32'd0;
                        end else begin
                            state      <= START;
                            pulse_mult <= !bus.issue_op;
                            pulse_div  <= bus.issue_op;
                        end
                    end
                end
                START: begin
                    // md_ready here is stale from a previous operation; not looked at
                    cnt   <= '0;
                    state <= bus.flush ? IDLE : WAIT;
                end
                WAIT: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else if (bus.md_ready) begin
                        state      <= DONE;
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= bus.md_exception ? EXC_RD : rd;
                        wb_data_q  <= bus.md_exception ? exc_code(op) : bus.md_result;
                    end else if (cnt == TIMEOUT_CNT) begin
                        state      <= DONE;
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= EXC_RD;
                        wb_data_q  <= exc_code(op);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // flush in START must kill the start pulse in the same cycle
    assign bus.md_mult  = pulse_mult && !bus.flush;
    assign bus.md_div   = pulse_div && !bus.flush;
    assign bus.md_a     = a_q;
    assign bus.md_b     = b_q;
    assign bus.busy     = (state == START) || (state == WAIT);
    assign bus.stall    = !reset && (bus.busy ||
                          ((state == IDLE) && bus.issue_valid && !bus.flush));
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: directed vector table, reset corner case, then random
// transactions checked against a latency/result model derived from the sequencing rules.
module tb_multdiv_sequencer;

    localparam int MAX_CYCLES = 4;
`ifdef MDSEQ_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic        op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        int          k;        // cycles from start pulse to md_ready; 0 = never
        logic        exc;
        logic [31:0] res;
        int          flush_c;  // cycle (0 = issue cycle) flush is high; -1 = none
        bit          hold;     // keep issue_valid high through DONE
        bit          spur;     // md_ready also high during START
        int          exp_wb;   // expected wb cycle; -1 = no writeback
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        bit          exp_pulse;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   txn_id = 0;

    multdiv_sequencer_if bus();

    multdiv_sequencer #(.MAX_CYCLES(MAX_CYCLES), .CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL txn %0d %s: got %0d expected %0d", txn_id, nm, $signed(act), $signed(exp));
        end
    endtask

    function automatic vec_t mk(input logic op, input logic [4:0] rd, input logic [31:0] a,
                                input logic [31:0] b, input int k, input logic exc,
                                input logic [31:0] res, input int flush_c, input bit hold,
                                input bit spur, input int exp_wb, input logic [4:0] exp_rd,
                                input logic [31:0] exp_data, input bit exp_pulse);
        vec_t v;
        v.op = op; v.rd = rd; v.a = a; v.b = b; v.k = k; v.exc = exc; v.res = res;
        v.flush_c = flush_c; v.hold = hold; v.spur = spur;
        v.exp_wb = exp_wb; v.exp_rd = exp_rd; v.exp_data = exp_data; v.exp_pulse = exp_pulse;
        return v;
    endfunction

    // Reference: writeback lands 2+k after issue if the unit answers within the window,
    // otherwise 2+MAX_CYCLES with a forced exception; a flush before that kills it.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit   fast, in_time, e;
        int   d;
        r = v;
        fast = FAST && (v.op ? (v.b == 0) : (v.a == 0 || v.b == 0));
        if (fast) begin
            r.exp_wb    = 1;
            r.exp_pulse = 1'b0;
            r.exp_rd    = v.op ? 5'd30 : v.rd;
            r.exp_data  = v.op ? 32'd5 : 32'd0;
            return r;
        end
        in_time = (v.k >= 1) && (v.k <= MAX_CYCLES);
        d = 2 + (in_time ? v.k : MAX_CYCLES);
        if (v.flush_c >= 1 && v.flush_c < d) begin
            r.exp_wb    = -1;
            r.exp_pulse = (v.flush_c >= 2);
            r.exp_rd    = '0;
            r.exp_data  = '0;
        end else begin
            e = in_time ? v.exc : 1'b1;
            r.exp_wb    = d;
            r.exp_pulse = 1'b1;
            r.exp_rd    = e ? 5'd30 : v.rd;
            r.exp_data  = e ? (v.op ? 32'd5 : 32'd4) : v.res;
        end
        return r;
    endfunction

    // Called just after a rising edge; plays the pipeline and the unit cycle by cycle.
    task automatic run_txn(input vec_t v);
        int   c, pc, wbc, nm, nd, nwb, last;
        bit   stall_ok, busy_ok, done, ready;
        logic [4:0]  grd;
        logic [31:0] gdata, ga, gb;
        pc = -1; wbc = -1; nm = 0; nd = 0; nwb = 0;
        stall_ok = 1'b1; busy_ok = 1'b1; done = 1'b0;
        grd = '0; gdata = '0; ga = '0; gb = '0;
        last = (v.exp_wb >= 0) ? v.exp_wb : v.flush_c + 1;
        c = 0;
        while (!done && c <= MAX_CYCLES + 10) begin
            bus.issue_valid = (c == 0) || (v.hold && wbc < 0);
            bus.issue_op    = v.op;
            bus.issue_rd    = v.rd;
            bus.operand_a   = v.a;
            bus.operand_b   = v.b;
            bus.flush       = (c == v.flush_c);
            ready = (pc >= 0 && v.k > 0 && c == pc + v.k) || (v.spur && c == 1);
            bus.md_ready     = ready;
            bus.md_exception = ready ? v.exc : 1'($urandom);
            bus.md_result    = ready ? v.res : $urandom;
            @(negedge clock);
            if (bus.md_mult) nm++;
            if (bus.md_div) nd++;
            if ((bus.md_mult || bus.md_div) && pc < 0) begin
                pc = c; ga = bus.md_a; gb = bus.md_b;
            end
            if (bus.wb_valid) begin
                nwb++;
                if (wbc < 0) begin
                    wbc = c; grd = bus.wb_rd; gdata = bus.wb_data;
                end
            end
            if (bus.stall !== (c < last)) stall_ok = 1'b0;
            if (bus.busy !== (c >= 1 && c < last && !(v.exp_wb == 1))) busy_ok = 1'b0;
            if (c >= last) done = 1'b1;
            @(posedge clock); #1;
            c++;
        end
        bus.issue_valid = 1'b0;
        bus.flush       = 1'b0;
        bus.md_ready    = 1'b0;
        chk("wb_cycle", wbc, v.exp_wb);
        chk("wb_count", nwb, (v.exp_wb >= 0) ? 1 : 0);
        if (v.exp_wb >= 0) begin
            chk("wb_rd", {27'd0, grd}, {27'd0, v.exp_rd});
            chk("wb_data", gdata, v.exp_data);
        end
        chk("mult_pulses", nm, (v.exp_pulse && !v.op) ? 1 : 0);
        chk("div_pulses", nd, (v.exp_pulse && v.op) ? 1 : 0);
        if (v.exp_pulse) begin
            chk("md_a", ga, v.a);
            chk("md_b", gb, v.b);
        end
        chk("stall_profile", {31'd0, stall_ok}, 32'd1);
        chk("busy_profile", {31'd0, busy_ok}, 32'd1);
        txn_id++;
    endtask

    vec_t tbl[14];
    vec_t rv;

    initial begin
        tbl[0]  = mk(0, 5, 6, 7, 3, 0, 42, -1, 0, 0, 5, 5, 42, 1);
        tbl[1]  = mk(1, 7, 100, 0, 2, 1, 0, -1, 0, 0, FAST ? 1 : 4, 30, 5, !FAST);
        tbl[2]  = mk(0, 3, 9, 9, 0, 0, 0, -1, 0, 0, 6, 30, 4, 1);
        tbl[3]  = mk(0, 8, 4, 5, 4, 0, 20, -1, 0, 0, 6, 8, 20, 1);
        tbl[4]  = mk(1, 1, 7, 3, 4, 1, 2, -1, 0, 0, 6, 30, 5, 1);
        tbl[5]  = mk(0, 4, 5, 5, 0, 0, 0, 3, 0, 0, -1, 0, 0, 1);
        tbl[6]  = mk(0, 2, 3, 3, 1, 0, 9, -1, 0, 0, 3, 2, 9, 1);
        tbl[7]  = mk(1, 13, 8, 2, 0, 0, 4, 1, 0, 0, -1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 11, 7, 1, 0, 77, -1, 0, 0, 3, 0, 77, 1);
        tbl[9]  = mk(0, 6, 0, 5, 2, 0, 0, -1, 0, 0, FAST ? 1 : 4, 6, 0, !FAST);
        tbl[10] = mk(0, 9, 2, 2, 2, 0, 4, -1, 0, 1, 4, 9, 4, 1);
        tbl[11] = mk(0, 10, 10, 10, 1, 0, 100, -1, 1, 0, 3, 10, 100, 1);
        tbl[12] = mk(1, 11, 20, 4, 2, 0, 5, -1, 1, 0, 4, 11, 5, 1);
        tbl[13] = mk(0, 12, 1, 1, 1, 0, 1, 3, 0, 0, 3, 12, 1, 1);

        reset = 1'b1;
        bus.issue_valid = 1'b1; bus.issue_op = 1'b0; bus.issue_rd = 5'd1;
        bus.operand_a = 32'd3; bus.operand_b = 32'd4; bus.flush = 1'b0;
        bus.md_result = '0; bus.md_exception = 1'b0; bus.md_ready = 1'b0;
        #2;
        chk("reset_stall", {31'd0, bus.stall}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("reset_md_a", bus.md_a, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        bus.issue_valid = 1'b0;
        @(posedge clock); #1;

        foreach (tbl[i]) run_txn(tbl[i]);

        // asynchronous reset in the middle of WAIT
        bus.issue_valid = 1'b1; bus.issue_op = 1'b0; bus.issue_rd = 5'd3;
        bus.operand_a = 32'd1; bus.operand_b = 32'd2;
        @(posedge clock); #1; bus.issue_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("busy_before_reset", {31'd0, bus.busy}, 32'd1);
        #3;
        reset = 1'b1;
        bus.issue_valid = 1'b1;
        #1;
        chk("midreset_stall", {31'd0, bus.stall}, 32'd0);
        chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
        chk("midreset_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("midreset_md_mult", {31'd0, bus.md_mult}, 32'd0);
        chk("midreset_md_div", {31'd0, bus.md_div}, 32'd0);
        chk("midreset_md_a", bus.md_a, 32'd0);
        #2;
        reset = 1'b0;
        bus.issue_valid = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("postreset_stall", {31'd0, bus.stall}, 32'd0);
        chk("postreset_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clock); #1;
        run_txn(tbl[6]);

        for (int i = 0; i < 80; i++) begin
            rv.op  = 1'($urandom);
            rv.rd  = 5'($urandom);
            rv.a   = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            rv.b   = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom_range(1, 1000);
            rv.k   = $urandom_range(0, MAX_CYCLES + 2);
            rv.exc = rv.op && (rv.b == 0);
            rv.res = rv.op ? ((rv.b == 0) ? 32'd0 : rv.a / rv.b) : rv.a * rv.b;
            rv.flush_c = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : -1;
            rv.hold = (rv.flush_c < 0) && ($urandom_range(0, 1) == 1);
            rv.spur = ($urandom_range(0, 3) == 0);
            run_txn(model(rv));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
